// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target receiving 3-byte write frames (address, two data bytes)
//   and presenting WM8731-style control words {reg_addr[6:0], reg_data[8:0]}.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   i2c_sclk        bus clock input (never driven, never stretched)
//   i2c_sdat        open-drain data line, driven only 0 or Z
//   dout            last accepted word
//   wr_valid        1-cycle strobe, dout valid in the same cycle
//   busy            address-matched write frame in progress
//   rej             1-cycle strobe on a rejected or aborted frame
// Option: define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter on both lines.
module i2c_target_rx #(
   parameter logic [6:0] DEV_ADDR = 7'h1A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i2c_sclk,
   inout  wire         i2c_sdat,
   output logic [15:0] dout,
   output logic        wr_valid,
   output logic        busy,
   output logic        rej
);
   typedef enum logic [2:0] {IDLE, ADDR, ACK, BYTE, DONE, IGNORE} state_t;
   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shreg_q, shreg_d, data1_q, data1_d;
   logic [15:0] dout_q, dout_d;
   logic        sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d, busy_q, busy_d, rej_q, rej_d;
   logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic        scl_prev_q, sda_prev_q;
   logic        scl_lvl, sda_lvl, rise, fall, start_c, stop_c, bit_last;
   logic [7:0]  byte_in;
`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0]  scl_h_q, scl_h_d, sda_h_q, sda_h_d;
   logic        scl_filt_q, sda_filt_q;
   // level follows the input only once it has been stable for 3 samples
   always_comb begin
      scl_h_d = {scl_h_q[0], scl_sync_q[1]};
      sda_h_d = {sda_h_q[0], sda_sync_q[1]};
      scl_lvl = (scl_h_q == {2{scl_sync_q[1]}}) ? scl_sync_q[1] : scl_filt_q;
      sda_lvl = (sda_h_q == {2{sda_sync_q[1]}}) ? sda_sync_q[1] : sda_filt_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         scl_h_q    <= 2'b11;
         sda_h_q    <= 2'b11;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_h_q    <= scl_h_d;
         sda_h_q    <= sda_h_d;
         scl_filt_q <= scl_lvl;
         sda_filt_q <= sda_lvl;
      end
`else
   assign scl_lvl = scl_sync_q[1];
   assign sda_lvl = sda_sync_q[1];
`endif
   always_comb begin
      scl_sync_d = {scl_sync_q[0], i2c_sclk};
      sda_sync_d = {sda_sync_q[0], i2c_sdat};
      rise       = scl_lvl & ~scl_prev_q;
      fall       = ~scl_lvl & scl_prev_q;
      start_c    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
      stop_c     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;
      byte_in    = {shreg_q[6:0], sda_lvl};
      bit_last   = bit_cnt_q == 3'd7;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shreg_d    = shreg_q;
      data1_d    = data1_q;
      sda_oe_d   = sda_oe_q;
      dout_d     = dout_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      rej_d      = 1'b0;
      // bus conditions win over bit sampling and abort any unfinished frame
      if (start_c || stop_c) begin
         rej_d      = state_q inside {ADDR, ACK, BYTE};
         state_d    = start_c ? ADDR : IDLE;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 2'd0;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b0;
      end else case (state_q)
         ADDR: if (rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_last) begin
               busy_d  = byte_in == {DEV_ADDR, 1'b0};
               rej_d   = byte_in != {DEV_ADDR, 1'b0};
               state_d = busy_d ? ACK : IGNORE;
            end
         end
         // sda_oe_q doubles as the phase marker: first fall drives, second releases
         ACK: if (fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) begin
               state_d    = (byte_cnt_q == 2'd2) ? DONE : BYTE;
               wr_valid_d = byte_cnt_q == 2'd2;
               dout_d     = (byte_cnt_q == 2'd2) ? {data1_q, shreg_q} : dout_q;
            end
         end
         BYTE: if (rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_last) begin
               data1_d    = (byte_cnt_q == 2'd0) ? byte_in : data1_q;
               byte_cnt_d = byte_cnt_q + 2'd1;
               state_d    = ACK;
            end
         end
         DONE: if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_last) begin
               rej_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IGNORE;
            end
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
         shreg_q    <= 8'd0;
         data1_q    <= 8'd0;
         sda_oe_q   <= 1'b0;
         dout_q     <= 16'd0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         rej_q      <= 1'b0;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shreg_q    <= shreg_d;
         data1_q    <= data1_d;
         sda_oe_q   <= sda_oe_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         rej_q      <= rej_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_lvl;
         sda_prev_q <= sda_lvl;
      end
   assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
   assign dout     = dout_q;
   assign wr_valid = wr_valid_q;
   assign busy     = busy_q;
   assign rej      = rej_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: randomized I2C write frames against a frame-level model with an event scoreboard.
module tb_i2c_target_rx;
   localparam int Q = 4;
   logic        clk = 1'b0, reset = 1'b1, scl_m = 1'b1, m_oe = 1'b0;
   wire         sda;
   logic [15:0] dout;
   logic        wr_valid, busy, rej;
   int          checks = 0, errors = 0;
   typedef struct packed {logic wr; logic [15:0] d;} ev_t;
   ev_t         exp_q[$];
   logic [15:0] m_dout = 16'd0;
   bit          in_frame = 0, pending_start = 0;

   assign sda = m_oe ? 1'b0 : 1'bz;
   pullup (sda);
   always #5 clk = ~clk;

   i2c_target_rx #(.DEV_ADDR(7'h1A)) dut (
      .clk(clk), .reset(reset), .i2c_sclk(scl_m), .i2c_sdat(sda),
      .dout(dout), .wr_valid(wr_valid), .busy(busy), .rej(rej)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit gl();
`ifdef I2C_GLITCH_FILTER_EN
      return $urandom_range(0, 2) == 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic start_cond();
      if (in_frame) begin
         m_oe = 1'b0; clks(Q); scl_m = 1'b1; clks(2*Q);
      end
      m_oe = 1'b1; clks(2*Q); scl_m = 1'b0; clks(Q);
      in_frame = 1;
   endtask

   task automatic stop_cond();
      m_oe = 1'b1; clks(Q); scl_m = 1'b1; clks(2*Q); m_oe = 1'b0; clks(2*Q);
      in_frame = 0;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      m_oe = !b; clks(Q); scl_m = 1'b1; clks(Q);
      if (glitch) begin
         m_oe = !m_oe; clks(1); m_oe = !m_oe; clks(Q-1);
      end else clks(Q);
      scl_m = 1'b0; clks(Q);
   endtask

   task automatic ack_slot(input bit ack_exp, input bit busy_exp, input int idx);
      m_oe = 1'b0; clks(Q); scl_m = 1'b1; clks(Q);
      chk($sformatf("ack_slot%0d", idx), 32'(sda), ack_exp ? 32'd0 : 32'd1);
      chk($sformatf("busy_slot%0d", idx), 32'(busy), 32'(busy_exp));
      clks(Q); scl_m = 1'b0; clks(Q);
   endtask

   // w holds up to 4 bytes MSB-first; p extra bits follow; the frame ends in STOP or repeated START
   task automatic run_frame(input logic [31:0] w, input int n, input int p, input bit stop_end);
      bit ok;
      ok = w[31:24] == {7'h1A, 1'b0};
      if (!ok) exp_q.push_back('{1'b0, 16'd0});
      else begin
         if (n >= 3) begin
            exp_q.push_back('{1'b1, w[23:8]});
            m_dout = w[23:8];
         end
         if (n != 3) exp_q.push_back('{1'b0, 16'd0});
      end
      if (!pending_start) start_cond();
      pending_start = 0;
      for (int i = 0; i < n; i++) begin
         for (int k = 7; k >= 0; k--) send_bit(w[31-8*i-(7-k)], gl());
         ack_slot(ok && i < 3, ok && i < 3, i);
      end
      for (int k = 0; k < p; k++) send_bit(1'($urandom_range(0, 1)), gl());
      if (stop_end) stop_cond();
      else begin
         start_cond();
         pending_start = 1;
      end
      clks(6);
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("dout_after_frame", 32'(dout), 32'(m_dout));
      chk("pending_events", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic reset_test();
      start_cond();
      for (int k = 7; k >= 0; k--) send_bit(k == 5 || k == 4 || k == 2, 1'b0);
      m_oe = 1'b0; clks(Q); scl_m = 1'b1; clks(Q);
      chk("ack_before_reset", 32'(sda), 32'd0);
      #3 reset = 1'b1;
      #1;
      chk("sda_in_reset", 32'(sda), 32'd1);
      chk("outs_in_reset", {13'd0, dout, wr_valid, rej, busy}, 32'd0);
      clks(3);
      reset = 1'b0;
      m_dout = 16'd0;
      clks(Q); scl_m = 1'b0; clks(Q);
      stop_cond();
      clks(6);
      chk("dout_after_reset", 32'(dout), 32'd0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset && (wr_valid || rej)) begin
            if (exp_q.size() == 0) chk("unexpected_event", {30'd0, wr_valid, rej}, 32'd0);
            else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("event_kind", {30'd0, wr_valid, rej}, e.wr ? 32'd2 : 32'd1);
               if (e.wr) chk("wr_dout", 32'(dout), 32'(e.d));
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      clks(3);
      chk("reset_outs", {13'd0, dout, wr_valid, rej, busy}, 32'd0);
      chk("reset_sda", 32'(sda), 32'd1);
      reset = 1'b0;
      clks(8);
      run_frame(32'h341E0000, 3, 0, 1);
      run_frame(32'h36000000, 1, 0, 1);
      run_frame(32'h340D5500, 3, 0, 1);
      run_frame(32'h35AB0000, 2, 0, 1);
      run_frame(32'h341297AA, 4, 0, 1);
      run_frame(32'h34120000, 2, 0, 1);
      run_frame(32'h34000000, 1, 4, 0);
      run_frame(32'h345AC300, 3, 0, 1);
      reset_test();
      run_frame(32'h34770100, 3, 0, 1);
      for (int t = 0; t < 16; t++) begin
         logic [31:0] w;
         w = $urandom;
         w[31:24] = ($urandom_range(0, 3) == 0) ? w[31:24] : 8'h34;
         run_frame(w, $urandom_range(1, 4),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                   t == 15 || $urandom_range(0, 3) != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Receive-side I2C target (slave) that answers the 3-byte write frames issued by the codec controller's I2C controller: START, 7-bit device address + R/W, two data bytes, STOP. It decodes WM8731-style control words (7-bit register address + 9-bit data) and presents each completed word as a single-cycle write strobe. It is the bus-functional counterpart used for loopback tests and as the register-port front end of the codec model.

## Interface
- `DEV_ADDR`, default `7'h1A`: 7-bit target address the block acknowledges.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i2c_sclk`  in  1  bus clock; the block never drives it and does not stretch it.
- `i2c_sdat`  inout  1  open-drain data line; the block drives only `1'b0` or `1'bz`.
- `dout`  out  16  last accepted word, `{reg_addr[6:0], reg_data[8:0]}`.
- `wr_valid`  out  1  one-cycle strobe; `dout` is valid in the same cycle.
- `busy`  out  1  high from an address-matched write START until STOP or abort.
- `rej`  out  1  one-cycle strobe on a rejected frame: mismatch, read request, extra byte, or short frame.

## Operation
- `i2c_sclk` and `i2c_sdat` are each passed through a 2-FF synchronizer. Edge detection is done on the synchronized (or filtered) levels only.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL high. Both are recognised in every state. START forces ADDR (repeated START). STOP forces IDLE.
- Data bits are sampled on the SCL rising edge, MSB first. SDA is driven or released only in the cycle after an SCL falling edge.
- Bit counter is 3 bits. Byte counter counts 0..2.
- **IDLE**: SDA released. Wait for START.
- **ADDR**: shift 8 bits. After the 8th bit:
  - `addr == DEV_ADDR` and R/W = 0 → ACK, `busy` = 1.
  - Otherwise → `rej` pulse, go to IGNORE with no ACK.
- **ACK**: on the falling SCL edge after the 8th bit, drive SDA low. On the next falling edge, release SDA. Then go to BYTE, or to DONE after the second data byte.
- **BYTE**: shift 8 bits.
  - Data byte 1 is `{reg_addr[6:0], reg_data[8]}`.
  - Data byte 2 is `reg_data[7:0]`.
  - Each data byte is ACKed.
- **DONE**: entered at the falling edge that ends the ACK of data byte 2. `dout` loads and `wr_valid` pulses in that cycle.
  - Any further byte clocked in DONE is not ACKed. It pulses `rej` once and moves to IGNORE.
  - `dout` and the write stay committed.
- **IGNORE**: SDA released, `busy` = 0. Wait for STOP or START.
- A STOP or START seen in ADDR, ACK or BYTE before DONE aborts the frame:
  - `rej` pulse.
  - No `wr_valid`.
  - `dout` keeps its previous value.
- `busy` clears on STOP, START, or entry to IGNORE.
- Reset values: `dout` = 0, `wr_valid` = 0, `busy` = 0, `rej` = 0, SDA released (Z), state IDLE, all counters 0.
- Reset asserted mid-frame releases SDA immediately (asynchronous path). After reset the block waits for a fresh START.

## Timing
- Input latency: 2 clk from pin to detected edge (4 clk with filter).
- SCL high and low phases must each last at least 4 clk (6 clk with filter). Below that the behaviour is unspecified.
- ACK drive asserts 1 clk after the SCL falling edge is detected, which is well inside the SCL low phase.
- `wr_valid` and `rej` are exactly 1 clk wide. At most one `wr_valid` is issued per frame.
- START/STOP detection has priority over bit sampling when both occur in the same cycle.

## Configuration
- `I2C_GLITCH_FILTER_EN`:
  - **Defined**: each synchronized line feeds a 3-sample stability filter. The filtered level changes only after 3 consecutive equal samples. This adds 2 clk of latency and rejects pulses of 2 clk or less.
  - **Undefined**: filtered level equals the synchronized level, with no extra latency.

## Test plan
- Address byte `0x34`, data `0x1E`, `0x00`, STOP → SDA low in all 3 ACK slots; one `wr_valid` with `dout` = `16'h1E00`; `busy` high during the frame and 0 after STOP.
- Address byte `0x36` (mismatch) → no ACK, `rej` = 1 pulse, no `wr_valid`. A following valid frame (`0x34`, `0x0D`, `0x55`) gives `dout` = `16'h0D55`.
- Address byte `0x35` (read) → no ACK, `rej` pulse, SDA stays Z until STOP.
- Frame `0x34`, `0x12`, `0x97`, `0xAA` → ACKs on the first 3 bytes, `wr_valid` with `dout` = `16'h1297`, no ACK on `0xAA`, `rej` pulse.
- STOP after `0x34`, `0x12` → `rej` pulse, no `wr_valid`, `dout` unchanged. Repeated START after the 4th bit of byte 1 → restart in ADDR, and the next full frame is accepted.
- `reset` pulsed while SDA is driven low in an ACK slot → SDA Z within the reset cycle, all outputs 0. The next frame completes normally. Repeat all cases with `I2C_GLITCH_FILTER_EN` defined plus 1-clk SDA glitches while SCL is high; no spurious START or STOP may be detected.
